// File: rtl/aq_vidu_vid_wbt_wb_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// aq_vidu_vid_wbt_wb_ctrl_pkg
//   Shared definitions for the vector write-back table (WBT) write-back
//   control slice.
//   - WBT geometry: entry count, entry index width and the default depth of
//     the VLSU pending FIFO.
//   - Producer type encodings (WB_VEC_TYPE_*). These are shared with the WBT
//     entries so that the producer type recorded in an entry and the source
//     driving its strobe use the same encoding.
//   - Internal selector for where the second issue slot is taken from.
//   - pkg_clog2: pointer width helper that never returns zero.
// ---------------------------------------------------------------------------
package aq_vidu_vid_wbt_wb_ctrl_pkg;

    localparam int WBT_ENTRY_NUM  = 32;
    localparam int WBT_IDX_W      = 5;
    localparam int WBT_PEND_DEPTH = 2;

    // Producer type of a write-back event.
    typedef enum logic [1:0] {
        WB_VEC_TYPE_NONE = 2'b00,
        WB_VEC_TYPE_VFPU = 2'b01,
        WB_VEC_TYPE_VLSU = 2'b10
    } wb_vec_type_e;

    // Source of the second (VLSU) issue slot in a given cycle.
    typedef enum logic [1:0] {
        SLOT1_NONE   = 2'b00,
        SLOT1_HEAD   = 2'b01,
        SLOT1_BYPASS = 2'b10
    } slot1_src_e;

    // Width needed to index n entries; at least 1 so a depth-1 FIFO still
    // gets a legal (single-valued) pointer.
    function automatic int pkg_clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/aq_vidu_vid_wbt_pend_fifo.sv
// ---------------------------------------------------------------------------
// aq_vidu_vid_wbt_pend_fifo
//   In-order pending FIFO for VLSU write-back indices that lost the per-entry
//   collision against a same-cycle VFPU strobe (or arrived while older VLSU
//   events were still waiting). DEPTH entries of IDX_W bits.
//
// Ports
//   forever_cpuclk  in   1        clock
//   cpurst_b        in   1        asynchronous active-low reset, clears all
//                                 state including stored indices
//   flush           in   1        synchronous flush, empties the FIFO next cycle
//   push            in   1        write push_idx at the tail
//   push_idx        in   IDX_W    index to store
//   pop             in   1        drop the head entry
//   head_idx        out  IDX_W    index at the head (valid when !empty)
//   full            out  1        DEPTH entries held
//   empty           out  1        no entries held
//   cnt             out  PTR_W+1  occupancy
//
// Pointers run modulo DEPTH and each carries a wrap bit that toggles on every
// wrap; equal pointers with equal wrap bits mean empty, differing wrap bits
// mean full. The caller never pushes when full nor pops when empty.
// ---------------------------------------------------------------------------
module aq_vidu_vid_wbt_pend_fifo
    import aq_vidu_vid_wbt_wb_ctrl_pkg::*;
#(
    parameter int DEPTH = WBT_PEND_DEPTH,
    parameter int IDX_W = WBT_IDX_W,
    parameter int PTR_W = pkg_clog2(WBT_PEND_DEPTH)
) (
    input  logic             forever_cpuclk,
    input  logic             cpurst_b,
    input  logic             flush,
    input  logic             push,
    input  logic [IDX_W-1:0] push_idx,
    input  logic             pop,
    output logic [IDX_W-1:0] head_idx,
    output logic             full,
    output logic             empty,
    output logic [PTR_W:0]   cnt
);

    logic [IDX_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             wr_wrap;
    logic             rd_wrap;

    // Advance a pointer modulo DEPTH (DEPTH need not be a power of two).
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        if (ptr == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return ptr + 1'b1;
    endfunction

    function automatic logic ptr_wraps(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1));
    endfunction

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            wr_wrap <= 1'b0;
            rd_wrap <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            // Stored indices are left in place; the pointers alone make them
            // unreachable.
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            wr_wrap <= 1'b0;
            rd_wrap <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_idx;
                wr_ptr      <= ptr_inc(wr_ptr);
                wr_wrap     <= wr_wrap ^ ptr_wraps(wr_ptr);
            end
            if (pop) begin
                rd_ptr  <= ptr_inc(rd_ptr);
                rd_wrap <= rd_wrap ^ ptr_wraps(rd_ptr);
            end
        end
    end

    assign head_idx = mem[rd_ptr];
    assign empty    = (wr_ptr == rd_ptr) && (wr_wrap == rd_wrap);
    assign full     = (wr_ptr == rd_ptr) && (wr_wrap != rd_wrap);

    // Occupancy: plain difference when both pointers are on the same lap,
    // otherwise the writer is one lap ahead.
    always_comb begin
        if (wr_wrap == rd_wrap) begin
            cnt = {1'b0, wr_ptr} - {1'b0, rd_ptr};
        end else begin
            cnt = (PTR_W + 1)'(DEPTH) + {1'b0, wr_ptr} - {1'b0, rd_ptr};
        end
    end

endmodule

// File: rtl/aq_vidu_vid_wbt_wb_ctrl.sv
// ---------------------------------------------------------------------------
// aq_vidu_vid_wbt_wb_ctrl
//   Write-back side driver of the vector write-back table. Merges per-cycle
//   completion events from the VFPU (slot0, always accepted) and the VLSU
//   (slot1, ready/valid) into one registered strobe vector wbt_wb_en, with at
//   most one strobe per entry per cycle: an entry counts exactly one producer
//   per strobe, so two producers hitting the same entry in one cycle would
//   lose a count. A VLSU event that cannot issue is parked in an in-order
//   pending FIFO and retried from there.
//
// Ports
//   forever_cpuclk         in   1          clock
//   cpurst_b               in   1          asynchronous active-low reset
//   rtu_vidu_flush_wbt     in   1          synchronous WBT flush
//   rtu_yy_xx_async_flush  in   1          async-class flush, sampled on clock
//   vfpu_vidu_wb_vld       in   1          VFPU completion, no backpressure
//   vfpu_vidu_wb_idx       in   IDX_W      VFPU destination vreg index
//   vlsu_vidu_wb_vld       in   1          VLSU completion request
//   vlsu_vidu_wb_idx       in   IDX_W      VLSU destination vreg index
//   vidu_vlsu_wb_rdy       out  1          VLSU request accepted this cycle
//   wbt_wb_en              out  ENTRY_NUM  per-entry write-back strobe
//   wbc_pend_cnt           out  PTR_W+1    pending FIFO occupancy (debug)
// ---------------------------------------------------------------------------
module aq_vidu_vid_wbt_wb_ctrl
    import aq_vidu_vid_wbt_wb_ctrl_pkg::*;
#(
    parameter int ENTRY_NUM = WBT_ENTRY_NUM,
    parameter int IDX_W     = WBT_IDX_W,
    parameter int DEPTH     = WBT_PEND_DEPTH,
    parameter int PTR_W     = pkg_clog2(WBT_PEND_DEPTH)
) (
    input  logic                 forever_cpuclk,
    input  logic                 cpurst_b,
    input  logic                 rtu_vidu_flush_wbt,
    input  logic                 rtu_yy_xx_async_flush,
    input  logic                 vfpu_vidu_wb_vld,
    input  logic [IDX_W-1:0]     vfpu_vidu_wb_idx,
    input  logic                 vlsu_vidu_wb_vld,
    input  logic [IDX_W-1:0]     vlsu_vidu_wb_idx,
    output logic                 vidu_vlsu_wb_rdy,
    output logic [ENTRY_NUM-1:0] wbt_wb_en,
    output logic [PTR_W:0]       wbc_pend_cnt
);

    logic                 flush;
    logic                 vlsu_acc;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [IDX_W-1:0]     fifo_head_idx;
    logic                 fifo_push;
    logic                 fifo_pop;
    slot1_src_e           slot1_src;
    logic [IDX_W-1:0]     slot1_idx;
    logic                 slot1_iss;
    logic [ENTRY_NUM-1:0] wb_en_p0;
    logic [ENTRY_NUM-1:0] wb_en_p1;

    // Indices beyond the table are illegal; they produce no strobe.
    function automatic logic idx_legal(input logic [IDX_W-1:0] idx);
        return (int'(idx) < ENTRY_NUM);
    endfunction

    function automatic logic [ENTRY_NUM-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
        logic [ENTRY_NUM-1:0] oh;
        oh = '0;
        if (idx_legal(idx)) begin
            oh[idx] = 1'b1;
        end
        return oh;
    endfunction

    assign flush = rtu_vidu_flush_wbt | rtu_yy_xx_async_flush;

    // Ready is taken from the registered FIFO state only, so it never waits
    // on this cycle's pop decision (no ready -> issue -> ready loop).
    assign vidu_vlsu_wb_rdy = !fifo_full && !flush;
    assign vlsu_acc         = vlsu_vidu_wb_vld && vidu_vlsu_wb_rdy;

    // ---- stage p0: issue selection and collision resolution ----
    always_comb begin
        slot1_src = SLOT1_NONE;
        slot1_idx = vlsu_vidu_wb_idx;
        // Older parked VLSU events go first; a new VLSU event may only
        // bypass the FIFO when nothing is waiting, which keeps VLSU order.
        if (!fifo_empty) begin
            slot1_src = SLOT1_HEAD;
            slot1_idx = fifo_head_idx;
        end else if (vlsu_acc) begin
            slot1_src = SLOT1_BYPASS;
        end

        slot1_iss = (slot1_src != SLOT1_NONE) &&
                    (!vfpu_vidu_wb_vld || (slot1_idx != vfpu_vidu_wb_idx));

        fifo_pop  = slot1_iss && (slot1_src == SLOT1_HEAD) && !flush;
        // vlsu_acc is already low during a flush, so nothing is pushed then.
        fifo_push = vlsu_acc && !(slot1_iss && (slot1_src == SLOT1_BYPASS));

        wb_en_p0 = '0;
        if (!flush) begin
            if (vfpu_vidu_wb_vld) begin
                wb_en_p0 = wb_en_p0 | idx_onehot(vfpu_vidu_wb_idx);
            end
            if (slot1_iss) begin
                wb_en_p0 = wb_en_p0 | idx_onehot(slot1_idx);
            end
        end
    end

    aq_vidu_vid_wbt_pend_fifo #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W),
        .PTR_W (PTR_W)
    ) x_aq_vidu_vid_wbt_pend_fifo (
        .forever_cpuclk (forever_cpuclk),
        .cpurst_b       (cpurst_b),
        .flush          (flush),
        .push           (fifo_push),
        .push_idx       (vlsu_vidu_wb_idx),
        .pop            (fifo_pop),
        .head_idx       (fifo_head_idx),
        .full           (fifo_full),
        .empty          (fifo_empty),
        .cnt            (wbc_pend_cnt)
    );

    // ---- stage p1: registered strobe vector ----
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            wb_en_p1 <= '0;
        end else begin
            wb_en_p1 <= wb_en_p0;
        end
    end

    assign wbt_wb_en = wb_en_p1;

    // Illegal destination indices are a producer bug.
    always @(posedge forever_cpuclk) begin
        if (cpurst_b && vfpu_vidu_wb_vld) begin
            assert (idx_legal(vfpu_vidu_wb_idx));
        end
        if (cpurst_b && vlsu_acc) begin
            assert (idx_legal(vlsu_vidu_wb_idx));
        end
    end

endmodule

// File: tb/tb_aq_vidu_vid_wbt_wb_ctrl.sv
// ---------------------------------------------------------------------------
// tb_aq_vidu_vid_wbt_wb_ctrl
//   Directed scenarios followed by a randomized run. A queue-based model of
//   the pending VLSU events predicts ready, the next-cycle strobe vector and
//   the occupancy each cycle.
// ---------------------------------------------------------------------------
module tb_aq_vidu_vid_wbt_wb_ctrl;

    localparam int ENTRY_NUM = 32;
    localparam int IDX_W     = 5;
    localparam int DEPTH     = 2;
    localparam int PTR_W     = 1;

    logic                 forever_cpuclk;
    logic                 cpurst_b;
    logic                 rtu_vidu_flush_wbt;
    logic                 rtu_yy_xx_async_flush;
    logic                 vfpu_vidu_wb_vld;
    logic [IDX_W-1:0]     vfpu_vidu_wb_idx;
    logic                 vlsu_vidu_wb_vld;
    logic [IDX_W-1:0]     vlsu_vidu_wb_idx;
    logic                 vidu_vlsu_wb_rdy;
    logic [ENTRY_NUM-1:0] wbt_wb_en;
    logic [PTR_W:0]       wbc_pend_cnt;

    int n_cmp;
    int n_err;

    // Model: indices of VLSU events waiting to be written back, oldest first.
    logic [IDX_W-1:0] pend_q[$];

    aq_vidu_vid_wbt_wb_ctrl #(
        .ENTRY_NUM (ENTRY_NUM),
        .IDX_W     (IDX_W),
        .DEPTH     (DEPTH),
        .PTR_W     (PTR_W)
    ) dut (
        .forever_cpuclk        (forever_cpuclk),
        .cpurst_b              (cpurst_b),
        .rtu_vidu_flush_wbt    (rtu_vidu_flush_wbt),
        .rtu_yy_xx_async_flush (rtu_yy_xx_async_flush),
        .vfpu_vidu_wb_vld      (vfpu_vidu_wb_vld),
        .vfpu_vidu_wb_idx      (vfpu_vidu_wb_idx),
        .vlsu_vidu_wb_vld      (vlsu_vidu_wb_vld),
        .vlsu_vidu_wb_idx      (vlsu_vidu_wb_idx),
        .vidu_vlsu_wb_rdy      (vidu_vlsu_wb_rdy),
        .wbt_wb_en             (wbt_wb_en),
        .wbc_pend_cnt          (wbc_pend_cnt)
    );

    initial forever_cpuclk = 1'b0;
    always #5 forever_cpuclk = ~forever_cpuclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: called just after a rising edge, drives the inputs,
    // checks ready mid-cycle, then checks the registered outputs after the
    // next rising edge.
    task automatic step(input logic fv, input logic [IDX_W-1:0] fi,
                        input logic lv, input logic [IDX_W-1:0] li,
                        input logic fl, input logic af, output logic acc);
        logic [31:0]      en;
        logic             m_rdy;
        logic             have_head;
        logic             s1_vld;
        logic [IDX_W-1:0] s1_idx;
        logic             s1_iss;
        vfpu_vidu_wb_vld      = fv;
        vfpu_vidu_wb_idx      = fi;
        vlsu_vidu_wb_vld      = lv;
        vlsu_vidu_wb_idx      = li;
        rtu_vidu_flush_wbt    = fl;
        rtu_yy_xx_async_flush = af;
        @(negedge forever_cpuclk);
        m_rdy = (pend_q.size() < DEPTH) && !(fl || af);
        chk("rdy", 32'(vidu_vlsu_wb_rdy), 32'(m_rdy));
        acc = lv && m_rdy;
        en  = '0;
        if (fl || af) begin
            pend_q.delete();
        end else begin
            if (fv) en = en | (32'(1) << fi);
            have_head = (pend_q.size() > 0);
            s1_vld    = have_head || acc;
            s1_idx    = have_head ? pend_q[0] : li;
            s1_iss    = s1_vld && (!fv || (s1_idx != fi));
            if (s1_iss) en = en | (32'(1) << s1_idx);
            if (s1_iss && have_head) void'(pend_q.pop_front());
            if (acc && !(s1_iss && !have_head)) pend_q.push_back(li);
        end
        @(posedge forever_cpuclk);
        #1;
        chk("wb_en", wbt_wb_en, en);
        chk("pend_cnt", 32'(wbc_pend_cnt), 32'(pend_q.size()));
    endtask

    task automatic idle(input int n);
        logic a;
        for (int k = 0; k < n; k++) begin
            step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, a);
        end
    endtask

    initial begin
        logic             acc;
        logic             lv_h;
        logic [IDX_W-1:0] li_h;
        logic             fv;
        logic [IDX_W-1:0] fi;
        logic             fl;
        logic             af;
        n_cmp = 0;
        n_err = 0;
        cpurst_b              = 1'b0;
        rtu_vidu_flush_wbt    = 1'b0;
        rtu_yy_xx_async_flush = 1'b0;
        vfpu_vidu_wb_vld      = 1'b0;
        vfpu_vidu_wb_idx      = '0;
        vlsu_vidu_wb_vld      = 1'b0;
        vlsu_vidu_wb_idx      = '0;

        // 1. reset then idle
        repeat (2) @(posedge forever_cpuclk);
        #1;
        chk("rst_wb_en", wbt_wb_en, 32'h0);
        chk("rst_pend_cnt", 32'(wbc_pend_cnt), 32'h0);
        @(negedge forever_cpuclk);
        cpurst_b = 1'b1;
        @(posedge forever_cpuclk);
        #1;
        chk("idle_rdy", 32'(vidu_vlsu_wb_rdy), 32'h1);
        chk("idle_wb_en", wbt_wb_en, 32'h0);
        chk("idle_pend_cnt", 32'(wbc_pend_cnt), 32'h0);
        idle(2);

        // 2. distinct indices issue together
        step(1'b1, 5'd3, 1'b1, 5'd7, 1'b0, 1'b0, acc);
        chk("t2_wb_en", wbt_wb_en, 32'h88);
        chk("t2_pend_cnt", 32'(wbc_pend_cnt), 32'h0);

        // 3. same index: VLSU deferred one cycle
        step(1'b1, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, acc);
        chk("t3a_wb_en", wbt_wb_en, 32'h20);
        chk("t3a_pend_cnt", 32'(wbc_pend_cnt), 32'h1);
        idle(1);
        chk("t3b_wb_en", wbt_wb_en, 32'h20);
        chk("t3b_pend_cnt", 32'(wbc_pend_cnt), 32'h0);
        idle(1);

        // 4. sustained collision fills the FIFO, then drains in order
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 5'd9, 1'b1, 5'd9, 1'b0, 1'b0, acc);
        end
        chk("t4_full_cnt", 32'(wbc_pend_cnt), 32'h2);
        chk("t4_full_rdy", 32'(vidu_vlsu_wb_rdy), 32'h0);
        idle(1);
        chk("t4_drain1_en", wbt_wb_en, 32'h200);
        chk("t4_drain1_cnt", 32'(wbc_pend_cnt), 32'h1);
        idle(1);
        chk("t4_drain2_en", wbt_wb_en, 32'h200);
        chk("t4_drain2_cnt", 32'(wbc_pend_cnt), 32'h0);
        idle(1);
        chk("t4_done_en", wbt_wb_en, 32'h0);

        // 5. flush drops the FIFO {4,6} and the same-cycle VFPU event
        step(1'b1, 5'd4, 1'b1, 5'd4, 1'b0, 1'b0, acc);
        step(1'b1, 5'd4, 1'b1, 5'd6, 1'b0, 1'b0, acc);
        chk("t5_fill_cnt", 32'(wbc_pend_cnt), 32'h2);
        step(1'b1, 5'd1, 1'b0, 5'd0, 1'b1, 1'b0, acc);
        chk("t5_flush_en", wbt_wb_en, 32'h0);
        chk("t5_flush_cnt", 32'(wbc_pend_cnt), 32'h0);
        idle(3);
        chk("t5_after_en", wbt_wb_en, 32'h0);

        // 6. reset in the middle of activity
        step(1'b1, 5'd9, 1'b1, 5'd9, 1'b0, 1'b0, acc);
        step(1'b1, 5'd9, 1'b1, 5'd9, 1'b0, 1'b0, acc);
        chk("t6_pre_cnt", 32'(wbc_pend_cnt), 32'h2);
        chk("t6_pre_en", wbt_wb_en, 32'h200);
        vfpu_vidu_wb_vld = 1'b0;
        vlsu_vidu_wb_vld = 1'b0;
        #2;
        cpurst_b = 1'b0;
        #1;
        chk("t6_rst_en", wbt_wb_en, 32'h0);
        chk("t6_rst_cnt", 32'(wbc_pend_cnt), 32'h0);
        pend_q.delete();
        @(negedge forever_cpuclk);
        cpurst_b = 1'b1;
        @(posedge forever_cpuclk);
        #1;
        idle(2);
        chk("t6_post_cnt", 32'(wbc_pend_cnt), 32'h0);

        // randomized traffic; the VLSU holds a request until accepted
        lv_h = 1'b0;
        li_h = '0;
        for (int i = 0; i < 600; i++) begin
            fv = ($urandom_range(0, 2) != 0);
            fi = IDX_W'($urandom_range(0, (i % 2 == 0) ? 7 : 31));
            if (!lv_h && ($urandom_range(0, 1) == 1)) begin
                lv_h = 1'b1;
                li_h = IDX_W'($urandom_range(0, (i % 3 == 0) ? 31 : 7));
            end
            fl = ($urandom_range(0, 29) == 0);
            af = ($urandom_range(0, 49) == 0);
            step(fv, fi, lv_h, li_h, fl, af, acc);
            if (acc) lv_h = 1'b0;
        end
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
